// File: rtl/writeback_queue_if.sv
// writeback_queue_if: result handshake (producer -> queue) and register file
// write port (queue -> register file) bundled for the writeback queue.
// master = producer/register-file side, slave = the queue itself.
interface writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // producer handshake
  logic          result_valid;
  logic          result_ready;
  logic [AW-1:0] result_reg;
  logic [DW-1:0] result_data;
  // register file write port
  logic          EnableWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  modport master (
    output result_valid, result_reg, result_data,
    input  result_ready, EnableWrite, write_reg, write_data
  );

  modport slave (
    input  result_valid, result_reg, result_data,
    output result_ready, EnableWrite, write_reg, write_data
  );
endinterface

// File: rtl/writeback_queue.sv
// Purpose: in-order writeback FIFO between MEM/WB and the register file write
//          port, with per-register pending status for decode hazard stalls.
// Latency: result accepted at edge N is written to the register file at edge
//          N+1 when the queue is empty and wb_hold is low.
// Backpressure: result_ready drops when DEPTH entries are queued; an offer
//          while not ready sets sticky err_overflow and must be held.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wb (slave)          result_valid/ready/reg/data in, EnableWrite/write_reg/
//                       write_data out to the register file
//   wb_hold             blocks draining this cycle
//   query_reg1/2        decode source indices; busy1/2 flag a queued write
//   count               number of queued entries
//   err_overflow        sticky offer-while-full flag
//   fwd1/2_valid/data   (only with `define WB_FORWARD_EN) youngest queued
//                       value for query_reg1/2
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  writeback_queue_if.slave           wb,
  input  logic                       wb_hold,
  input  logic [AW-1:0]              query_reg1,
  input  logic [AW-1:0]              query_reg2,
  output logic                       busy1,
  output logic                       busy2,
  output logic [$clog2(DEPTH):0]     count,
`ifdef WB_FORWARD_EN
  output logic                       fwd1_valid,
  output logic [DW-1:0]              fwd1_data,
  output logic                       fwd2_valid,
  output logic [DW-1:0]              fwd2_data,
`endif
  output logic                       err_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] dat;
  } entry_t;

  entry_t          entries_q [DEPTH];
  entry_t          entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;

  logic            accept;
  logic            push;
  logic            pop;

  always_comb begin
    // Readiness depends only on current occupancy; a same-cycle drain does not
    // open a slot early.
    wb.result_ready = (count_q != FULL);
    accept          = wb.result_valid && wb.result_ready;
    // Register 0 is never written, so such results are acknowledged but dropped.
    push            = accept && (wb.result_reg != '0);
    pop             = (count_q != '0) && !wb_hold;

    wb.EnableWrite  = pop;
    wb.write_reg    = pop ? entries_q[rd_ptr_q].rd  : '0;
    wb.write_data   = pop ? entries_q[rd_ptr_q].dat : '0;

    entries_d = entries_q;
    valid_d   = valid_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    // Pointers only coincide when empty (no pop) or full (no push), so the
    // pop clear and push set never target the same slot.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      entries_d[wr_ptr_q].rd  = wb.result_reg;
      entries_d[wr_ptr_q].dat = wb.result_data;
      valid_d[wr_ptr_q]       = 1'b1;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
    err_d   = err_q || (wb.result_valid && !wb.result_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign count        = count_q;
  assign err_overflow = err_q;

  // Pending status covers every valid slot, including the head being written.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entries_q[i].rd == query_reg1) && (query_reg1 != '0))
        busy1 = 1'b1;
      if (valid_q[i] && (entries_q[i].rd == query_reg2) && (query_reg2 != '0))
        busy2 = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Walk from oldest to youngest; the last match seen is the youngest value.
  logic [PW-1:0] fwd_idx;
  always_comb begin
    fwd1_data = '0;
    fwd2_data = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (valid_q[fwd_idx] && (entries_q[fwd_idx].rd == query_reg1) && (query_reg1 != '0))
        fwd1_data = entries_q[fwd_idx].dat;
      if (valid_q[fwd_idx] && (entries_q[fwd_idx].rd == query_reg2) && (query_reg2 != '0))
        fwd2_data = entries_q[fwd_idx].dat;
    end
  end
  assign fwd1_valid = busy1;
  assign fwd2_valid = busy2;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, single write, fill/overflow,
// register-0 drop, streaming with pointer wrap, same-register ordering and
// mid-operation reset. Writes are logged on the falling edge and compared
// against an expected list at the end.
module tb_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          wb_hold;
  logic [AW-1:0] query_reg1, query_reg2;
  logic          busy1, busy2;
  logic [CW-1:0] count;
  logic          err_overflow;
`ifdef WB_FORWARD_EN
  logic          fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  writeback_queue_if #(.AW(AW), .DW(DW)) wbi ();

  writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wbi),
    .wb_hold      (wb_hold),
    .query_reg1   (query_reg1),
    .query_reg2   (query_reg2),
    .busy1        (busy1),
    .busy2        (busy2),
    .count        (count),
`ifdef WB_FORWARD_EN
    .fwd1_valid   (fwd1_valid),
    .fwd1_data    (fwd1_data),
    .fwd2_valid   (fwd2_valid),
    .fwd2_data    (fwd2_data),
`endif
    .err_overflow (err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] wlog [$];
  logic [AW+DW-1:0] wexp [$];

  // Inputs settle right after the rising edge; the falling edge sees the write
  // that the register file will capture on the next rising edge.
  always @(negedge clk) begin
    if (!rst && wbi.EnableWrite === 1'b1)
      wlog.push_back({wbi.write_reg, wbi.write_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wbi.result_valid = 1'b1;
    wbi.result_reg   = r;
    wbi.result_data  = d;
  endtask

  task automatic idle_in();
    wbi.result_valid = 1'b0;
    wbi.result_reg   = '0;
    wbi.result_data  = '0;
  endtask

  initial begin
    rst        = 1'b1;
    wb_hold    = 1'b0;
    query_reg1 = '0;
    query_reg2 = '0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_count", count, 0);
    chk("rst_ready", wbi.result_ready, 1);
    chk("rst_we", wbi.EnableWrite, 0);
    chk("rst_wreg", wbi.write_reg, 0);
    chk("rst_wdata", wbi.write_data, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_err", err_overflow, 0);

    // single result, reg 5
    query_reg1 = 5;
    offer(5, 32'h0000_00AA);
    #1;
    chk("t1_busy_offer", busy1, 0);
    tick();
    idle_in();
    #1;
    chk("t1_we", wbi.EnableWrite, 1);
    chk("t1_wreg", wbi.write_reg, 5);
    chk("t1_wdata", wbi.write_data, 32'hAA);
    chk("t1_busy1", busy1, 1);
    chk("t1_count", count, 1);
    wexp.push_back({5'd5, 32'h0000_00AA});
    tick();
    #1;
    chk("t1_we_off", wbi.EnableWrite, 0);
    chk("t1_count0", count, 0);
    chk("t1_busy1_off", busy1, 0);
    chk("t1_wreg0", wbi.write_reg, 0);

    // fill under hold, then overflow attempt
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(AW'(i), DW'(32'h10 + i));
      tick();
    end
    idle_in();
    #1;
    chk("t2_count4", count, 4);
    chk("t2_ready0", wbi.result_ready, 0);
    chk("t2_we_hold", wbi.EnableWrite, 0);
    chk("t2_err_pre", err_overflow, 0);
    offer(9, 32'h99);
    tick();
    idle_in();
    #1;
    chk("t2_err", err_overflow, 1);
    chk("t2_count_still4", count, 4);
    wb_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_drain_we", wbi.EnableWrite, 1);
      chk("t2_drain_reg", wbi.write_reg, i);
      chk("t2_drain_data", wbi.write_data, 32'h10 + i);
      wexp.push_back({AW'(i), DW'(32'h10 + i)});
      tick();
    end
    #1;
    chk("t2_count0", count, 0);
    chk("t2_we_off", wbi.EnableWrite, 0);
    chk("t2_err_sticky", err_overflow, 1);

    // register 0 is acknowledged and dropped
    query_reg1 = '0;
    offer(0, 32'hFFFF_FFFF);
    #1;
    chk("t3_ready", wbi.result_ready, 1);
    tick();
    idle_in();
    #1;
    chk("t3_count", count, 0);
    chk("t3_we", wbi.EnableWrite, 0);
    tick();
    #1;
    chk("t3_we_later", wbi.EnableWrite, 0);

    // clear sticky error
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("r2_err", err_overflow, 0);

    // streaming, one push per cycle; pointers wrap
    for (int i = 0; i < 10; i++) begin
      offer(AW'(8 + i), DW'(32'h100 + i));
      #1;
      chk("t4_count_le1", (count <= 1), 1);
      chk("t4_we", wbi.EnableWrite, (i != 0));
      if (i != 0) chk("t4_wreg", wbi.write_reg, 8 + i - 1);
      wexp.push_back({AW'(8 + i), DW'(32'h100 + i)});
      tick();
    end
    idle_in();
    #1;
    chk("t4_last_we", wbi.EnableWrite, 1);
    chk("t4_last_reg", wbi.write_reg, 17);
    tick();
    #1;
    chk("t4_count0", count, 0);
    chk("t4_err", err_overflow, 0);

    // two writes to the same register
    wb_hold    = 1'b1;
    query_reg1 = 7;
    query_reg2 = 3;
    offer(7, 32'd1);
    tick();
    offer(7, 32'd2);
    tick();
    idle_in();
    #1;
    chk("t5_busy1", busy1, 1);
    chk("t5_busy2", busy2, 0);
    chk("t5_count", count, 2);
`ifdef WB_FORWARD_EN
    chk("t5_fwd1_valid", fwd1_valid, 1);
    chk("t5_fwd1_data", fwd1_data, 2);
    chk("t5_fwd2_valid", fwd2_valid, 0);
    chk("t5_fwd2_data", fwd2_data, 0);
`endif
    wb_hold = 1'b0;
    #1;
    chk("t5_we1", wbi.EnableWrite, 1);
    chk("t5_data1", wbi.write_data, 1);
    wexp.push_back({5'd7, 32'd1});
    tick();
    #1;
    chk("t5_data2", wbi.write_data, 2);
    chk("t5_busy_mid", busy1, 1);
    wexp.push_back({5'd7, 32'd2});
    tick();
    #1;
    chk("t5_busy_off", busy1, 0);
    chk("t5_we_off", wbi.EnableWrite, 0);

    // reset with queued entries discards them
    wb_hold    = 1'b1;
    query_reg1 = 20;
    query_reg2 = 22;
    for (int i = 0; i < 3; i++) begin
      offer(AW'(20 + i), DW'(32'h200 + i));
      tick();
    end
    idle_in();
    #1;
    chk("t6_count3", count, 3);
    chk("t6_busy1", busy1, 1);
    chk("t6_busy2", busy2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_count0", count, 0);
    chk("t6_busy1_off", busy1, 0);
    chk("t6_busy2_off", busy2, 0);
    chk("t6_we", wbi.EnableWrite, 0);
    chk("t6_err", err_overflow, 0);
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_no_write", wbi.EnableWrite, 0);
      tick();
    end

    // full write log
    chk("log_size", wlog.size(), wexp.size());
    for (int i = 0; i < wexp.size(); i++) begin
      if (i < wlog.size())
        chk($sformatf("log_%0d", i), wlog[i], wexp[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
